// File: rtl/alu_sequencer_if.sv
// Stream and ALU signal bundle for the ALU command sequencer.
// master = sequencer side, slave = host / ALU / consumer side.
interface alu_sequencer_if #(
    parameter int bitness = 8
);
    logic [bitness-1:0] rx_data;
    logic               rx_valid;
    logic               rx_ready;

    logic [bitness-1:0] alu_num_1;
    logic [bitness-1:0] alu_num_2;
    logic [7:0]         alu_op_code;
    logic               alu_i_ready;
    logic [bitness-1:0] alu_result_Hi;
    logic [bitness-1:0] alu_result_Lo;
    logic               alu_o_ready;

    logic [bitness-1:0] tx_data;
    logic               tx_valid;
    logic               tx_ready;

    logic               busy;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready,
        output alu_num_1, alu_num_2, alu_op_code, alu_i_ready,
        input  alu_result_Hi, alu_result_Lo, alu_o_ready,
        output tx_data, tx_valid,
        input  tx_ready,
        output busy
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready,
        input  alu_num_1, alu_num_2, alu_op_code, alu_i_ready,
        output alu_result_Hi, alu_result_Lo, alu_o_ready,
        input  tx_data, tx_valid,
        output tx_ready,
        input  busy
    );
endinterface

// File: rtl/alu_sequencer.sv
// Collects op/operand words, issues one ALU request, and streams back
// status/Hi/Lo; divide-by-zero is screened and silent ops time out.
module alu_sequencer #(
    parameter int         bitness = 8,
    parameter logic [7:0] div     = 8'b00000100,
    parameter int         timeout = 16
) (
    input  logic           clk,
    input  logic           reset,
    alu_sequencer_if.master bus
);

    localparam int timer_w = (timeout > 2) ? $clog2(timeout) : 1;
    localparam logic [timer_w-1:0] timer_last = timer_w'(timeout - 1);

    localparam logic [7:0] status_ok      = 8'h00;
    localparam logic [7:0] status_div0    = 8'h01;
    localparam logic [7:0] status_timeout = 8'h02;

    typedef enum logic [2:0] {
        GET_OP,
        GET_A,
        GET_B,
        ISSUE,
        WAIT,
        SEND_ST,
        SEND_HI,
        SEND_LO
    } state_t;

    state_t               state_reg;
    logic [7:0]           op_reg;
    logic [bitness-1:0]   num_1_reg;
    logic [7:0]           status_reg;
    logic [bitness-1:0]   hi_reg;
    logic [bitness-1:0]   lo_reg;
    logic [timer_w-1:0]   timer_reg;

    logic [bitness-1:0]   alu_num_1_reg;
    logic [bitness-1:0]   alu_num_2_reg;
    logic [7:0]           alu_op_code_reg;
    logic                 alu_i_ready_reg;
    logic                 rx_ready_reg;
    logic                 tx_valid_reg;
    logic [bitness-1:0]   tx_data_reg;
    logic                 busy_reg;

    logic rx_fire;
    logic tx_fire;

    assign rx_fire = bus.rx_valid && rx_ready_reg;
    assign tx_fire = tx_valid_reg && bus.tx_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= GET_OP;
            op_reg          <= '0;
            num_1_reg       <= '0;
            status_reg      <= '0;
            hi_reg          <= '0;
            lo_reg          <= '0;
            timer_reg       <= '0;
            alu_num_1_reg   <= '0;
            alu_num_2_reg   <= '0;
            alu_op_code_reg <= '0;
            alu_i_ready_reg <= 1'b0;
            rx_ready_reg    <= 1'b1;
            tx_valid_reg    <= 1'b0;
            tx_data_reg     <= '0;
            busy_reg        <= 1'b0;
        end else begin
            // The request strobe is only ever raised for the single ISSUE cycle.
            alu_i_ready_reg <= 1'b0;

            case (state_reg)
                GET_OP: begin
                    if (rx_fire) begin
                        op_reg    <= bus.rx_data[7:0];
                        busy_reg  <= 1'b1;
                        state_reg <= GET_A;
                    end
                end

                GET_A: begin
                    if (rx_fire) begin
                        num_1_reg <= bus.rx_data;
                        state_reg <= GET_B;
                    end
                end

                GET_B: begin
                    if (rx_fire) begin
                        alu_num_1_reg   <= num_1_reg;
                        alu_num_2_reg   <= bus.rx_data;
                        alu_op_code_reg <= op_reg;
                        rx_ready_reg    <= 1'b0;
                        if (op_reg == div && bus.rx_data == '0) begin
                            status_reg   <= status_div0;
                            hi_reg       <= '0;
                            lo_reg       <= '0;
                            tx_valid_reg <= 1'b1;
                            tx_data_reg  <= bitness'(status_div0);
                            state_reg    <= SEND_ST;
                        end else begin
                            alu_i_ready_reg <= 1'b1;
                            state_reg       <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    timer_reg <= '0;
                    state_reg <= WAIT;
                end

                WAIT: begin
                    // A completion landing on the expiry edge still wins.
                    if (bus.alu_o_ready) begin
                        status_reg   <= status_ok;
                        hi_reg       <= bus.alu_result_Hi;
                        lo_reg       <= bus.alu_result_Lo;
                        tx_valid_reg <= 1'b1;
                        tx_data_reg  <= bitness'(status_ok);
                        state_reg    <= SEND_ST;
                    end else if (timer_reg == timer_last) begin
                        status_reg   <= status_timeout;
                        hi_reg       <= '0;
                        lo_reg       <= '0;
                        tx_valid_reg <= 1'b1;
                        tx_data_reg  <= bitness'(status_timeout);
                        state_reg    <= SEND_ST;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end

                SEND_ST: begin
                    if (tx_fire) begin
                        tx_data_reg <= hi_reg;
                        state_reg   <= SEND_HI;
                    end
                end

                SEND_HI: begin
                    if (tx_fire) begin
                        tx_data_reg <= lo_reg;
                        state_reg   <= SEND_LO;
                    end
                end

                SEND_LO: begin
                    if (tx_fire) begin
                        tx_valid_reg <= 1'b0;
                        tx_data_reg  <= '0;
                        rx_ready_reg <= 1'b1;
                        busy_reg     <= 1'b0;
                        state_reg    <= GET_OP;
                    end
                end

                default: begin
                    tx_valid_reg <= 1'b0;
                    rx_ready_reg <= 1'b1;
                    busy_reg     <= 1'b0;
                    state_reg    <= GET_OP;
                end
            endcase
        end
    end

    assign bus.rx_ready    = rx_ready_reg;
    assign bus.alu_num_1   = alu_num_1_reg;
    assign bus.alu_num_2   = alu_num_2_reg;
    assign bus.alu_op_code = alu_op_code_reg;
    assign bus.alu_i_ready = alu_i_ready_reg;
    assign bus.tx_data     = tx_data_reg;
    assign bus.tx_valid    = tx_valid_reg;
    assign bus.busy        = busy_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small registered ALU model
// (add/mul/div acknowledge, anything else stays silent).
module tb_alu_sequencer;

    localparam int bitness = 8;
    localparam int timeout = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    alu_sequencer_if #(.bitness(bitness)) bus ();

    alu_sequencer #(
        .bitness(bitness),
        .div    (8'h04),
        .timeout(timeout)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int issue_cnt   = 0;
    int alu_pulses  = 0;
    int alu_delay   = 0;
    logic alu_pend  = 1'b0;
    int alu_cnt     = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bus.alu_i_ready) issue_cnt <= issue_cnt + 1;

    // {Hi, Lo}: add/mul give low byte in Hi and carry/high byte in Lo; div gives quotient/remainder.
    function automatic logic [15:0] alu_calc(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] r;
        r = '0;
        case (op)
            8'h01: r = 16'(a) + 16'(b);
            8'h02: r = 16'(a) * 16'(b);
            default: r = '0;
        endcase
        if (op == 8'h04) return (b != 0) ? {a / b, a % b} : 16'h0000;
        return {r[7:0], r[15:8]};
    endfunction

    always @(posedge clk) begin
        bus.alu_o_ready <= 1'b0;
        if (bus.alu_i_ready && (bus.alu_op_code == 8'h01 || bus.alu_op_code == 8'h02 || bus.alu_op_code == 8'h04)) begin
            if (alu_delay == 0) begin
                bus.alu_o_ready <= 1'b1;
                {bus.alu_result_Hi, bus.alu_result_Lo} <= alu_calc(bus.alu_op_code, bus.alu_num_1, bus.alu_num_2);
                alu_pulses <= alu_pulses + 1;
            end else begin
                alu_pend <= 1'b1;
                alu_cnt  <= alu_delay;
            end
        end else if (alu_pend) begin
            if (alu_cnt == 1) begin
                bus.alu_o_ready <= 1'b1;
                {bus.alu_result_Hi, bus.alu_result_Lo} <= alu_calc(bus.alu_op_code, bus.alu_num_1, bus.alu_num_2);
                alu_pulses <= alu_pulses + 1;
                alu_pend   <= 1'b0;
            end else begin
                alu_cnt <= alu_cnt - 1;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_word(input logic [7:0] d, output int t_acc);
        int n;
        bus.rx_data  = d;
        bus.rx_valid = 1'b1;
        n = 0;
        while (!bus.rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!bus.rx_ready) begin
            miscompares++;
            $display("FAIL rx_wait: rx_ready=0 after %0d cycles, required 1", n);
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        t_acc = cyc;
        $display("rx word %h accepted at cycle %0d", d, cyc);
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b, output int t_acc);
        int t;
        send_word(op, t);
        send_word(a, t);
        send_word(b, t_acc);
    endtask

    // Collects three response words with tx_ready held high.
    task automatic recv_resp(output logic [7:0] w0, output logic [7:0] w1, output logic [7:0] w2, output int t_first);
        logic [7:0] w [3];
        int n;
        t_first = 0;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!bus.tx_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            vectors++;
            if (!bus.tx_valid) begin
                miscompares++;
                $display("FAIL tx_wait word %0d: tx_valid=0 after %0d cycles, required 1", k, n);
            end
            if (k == 0) t_first = cyc;
            w[k] = bus.tx_data;
            $display("tx word %0d = %h at cycle %0d", k, w[k], cyc);
            @(negedge clk);
        end
        w0 = w[0];
        w1 = w[1];
        w2 = w[2];
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        vectors += 6;
        if (bus.rx_ready !== 1'b1) begin miscompares++; $display("FAIL reset_rx_ready: got %b, required 1", bus.rx_ready); end
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
        if (bus.tx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_tx_valid: got %b, required 0", bus.tx_valid); end
        if (bus.alu_i_ready !== 1'b0) begin miscompares++; $display("FAIL reset_alu_i_ready: got %b, required 0", bus.alu_i_ready); end
        if (bus.tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data: got %h, required 00", bus.tx_data); end
        if (bus.alu_op_code !== 8'h00) begin miscompares++; $display("FAIL reset_alu_op_code: got %h, required 00", bus.alu_op_code); end
        reset = 1'b1;
        @(negedge clk);
        vectors += 2;
        if (bus.rx_ready !== 1'b1) begin miscompares++; $display("FAIL idle_rx_ready: got %b, required 1", bus.rx_ready); end
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b, required 0", bus.busy); end
    endtask

    task automatic test_add;
        int t_acc, t_first, iss;
        logic [7:0] s, h, l;
        iss = issue_cnt;
        send_cmd(8'h01, 8'h05, 8'h03, t_acc);
        recv_resp(s, h, l, t_first);
        vectors += 7;
        if (s !== 8'h00) begin miscompares++; $display("FAIL add_status: got %h, required 00", s); end
        if (h !== 8'h08) begin miscompares++; $display("FAIL add_hi: got %h, required 08", h); end
        if (l !== 8'h00) begin miscompares++; $display("FAIL add_lo: got %h, required 00", l); end
        if (t_first - t_acc !== 2) begin miscompares++; $display("FAIL add_latency: got %0d cycles, required 2", t_first - t_acc); end
        if (issue_cnt - iss !== 1) begin miscompares++; $display("FAIL add_issue_count: got %0d, required 1", issue_cnt - iss); end
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL add_busy_after: got %b, required 0", bus.busy); end
        if (bus.rx_ready !== 1'b1) begin miscompares++; $display("FAIL add_rx_ready_after: got %b, required 1", bus.rx_ready); end
    endtask

    task automatic test_div;
        int t_acc, t_first, iss;
        logic [7:0] s, h, l;
        iss = issue_cnt;
        send_cmd(8'h04, 8'd17, 8'd5, t_acc);
        recv_resp(s, h, l, t_first);
        vectors += 4;
        if (s !== 8'h00) begin miscompares++; $display("FAIL div_status: got %h, required 00", s); end
        if (h !== 8'h03) begin miscompares++; $display("FAIL div_quotient: got %h, required 03", h); end
        if (l !== 8'h02) begin miscompares++; $display("FAIL div_remainder: got %h, required 02", l); end
        if (issue_cnt - iss !== 1) begin miscompares++; $display("FAIL div_issue_count: got %0d, required 1", issue_cnt - iss); end
    endtask

    task automatic test_div_zero;
        int t_acc, t_first, iss;
        logic [7:0] s, h, l;
        iss = issue_cnt;
        send_cmd(8'h04, 8'h09, 8'h00, t_acc);
        recv_resp(s, h, l, t_first);
        vectors += 4;
        if (s !== 8'h01) begin miscompares++; $display("FAIL div0_status: got %h, required 01", s); end
        if (h !== 8'h00) begin miscompares++; $display("FAIL div0_hi: got %h, required 00", h); end
        if (l !== 8'h00) begin miscompares++; $display("FAIL div0_lo: got %h, required 00", l); end
        if (issue_cnt - iss !== 0) begin miscompares++; $display("FAIL div0_issue_count: got %0d, required 0", issue_cnt - iss); end
    endtask

    task automatic test_timeout;
        int t_acc, t_first, iss;
        logic [7:0] s, h, l;
        iss = issue_cnt;
        send_cmd(8'h07, 8'h01, 8'h01, t_acc);
        vectors += 1;
        if (bus.alu_i_ready !== 1'b1) begin miscompares++; $display("FAIL to_issue_strobe: got %b, required 1", bus.alu_i_ready); end
        @(negedge clk);
        vectors += 5;
        if (bus.alu_i_ready !== 1'b0) begin miscompares++; $display("FAIL to_wait_strobe: got %b, required 0", bus.alu_i_ready); end
        if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL to_wait_busy: got %b, required 1", bus.busy); end
        if (bus.rx_ready !== 1'b0) begin miscompares++; $display("FAIL to_wait_rx_ready: got %b, required 0", bus.rx_ready); end
        if (bus.alu_op_code !== 8'h07) begin miscompares++; $display("FAIL to_wait_op_code: got %h, required 07", bus.alu_op_code); end
        if (bus.alu_num_1 !== 8'h01) begin miscompares++; $display("FAIL to_wait_num_1: got %h, required 01", bus.alu_num_1); end
        recv_resp(s, h, l, t_first);
        vectors += 5;
        if (s !== 8'h02) begin miscompares++; $display("FAIL to_status: got %h, required 02", s); end
        if (h !== 8'h00) begin miscompares++; $display("FAIL to_hi: got %h, required 00", h); end
        if (l !== 8'h00) begin miscompares++; $display("FAIL to_lo: got %h, required 00", l); end
        if (t_first - t_acc !== timeout + 1) begin miscompares++; $display("FAIL to_latency: got %0d cycles, required %0d", t_first - t_acc, timeout + 1); end
        if (issue_cnt - iss !== 1) begin miscompares++; $display("FAIL to_issue_count: got %0d, required 1", issue_cnt - iss); end
    endtask

    task automatic test_timeout_race;
        int t_acc, t_first;
        logic [7:0] s, h, l;
        alu_delay = timeout - 1;
        send_cmd(8'h01, 8'hF0, 8'h20, t_acc);
        recv_resp(s, h, l, t_first);
        alu_delay = 0;
        vectors += 4;
        if (s !== 8'h00) begin miscompares++; $display("FAIL race_status: got %h, required 00", s); end
        if (h !== 8'h10) begin miscompares++; $display("FAIL race_hi: got %h, required 10", h); end
        if (l !== 8'h01) begin miscompares++; $display("FAIL race_lo: got %h, required 01", l); end
        if (t_first - t_acc !== timeout + 1) begin miscompares++; $display("FAIL race_latency: got %0d cycles, required %0d", t_first - t_acc, timeout + 1); end
    endtask

    task automatic test_backpressure;
        int t_acc, t_first, n;
        logic [7:0] exp_w [3];
        logic [7:0] s, h, l;
        exp_w[0] = 8'h00;
        exp_w[1] = 8'h05;
        exp_w[2] = 8'h00;
        bus.tx_ready = 1'b0;
        send_cmd(8'h01, 8'h02, 8'h03, t_acc);
        // Next command's op word is offered the whole time the response is stalled.
        bus.rx_data  = 8'h01;
        bus.rx_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!bus.tx_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            vectors += 2;
            if (!bus.tx_valid) begin miscompares++; $display("FAIL bp_wait word %0d: tx_valid=0, required 1", k); end
            if (bus.tx_data !== exp_w[k]) begin miscompares++; $display("FAIL bp_word %0d: got %h, required %h", k, bus.tx_data, exp_w[k]); end
            $display("tx word %0d = %h stalled at cycle %0d", k, bus.tx_data, cyc);
            repeat (5) begin
                @(negedge clk);
                vectors += 4;
                if (bus.tx_data !== exp_w[k]) begin miscompares++; $display("FAIL bp_stable word %0d: got %h, required %h", k, bus.tx_data, exp_w[k]); end
                if (bus.tx_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid word %0d: got %b, required 1", k, bus.tx_valid); end
                if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL bp_busy word %0d: got %b, required 1", k, bus.busy); end
                if (bus.rx_ready !== 1'b0) begin miscompares++; $display("FAIL bp_rx_ready word %0d: got %b, required 0", k, bus.rx_ready); end
            end
            bus.tx_ready = 1'b1;
            @(negedge clk);
            bus.tx_ready = 1'b0;
        end
        vectors += 2;
        if (bus.rx_ready !== 1'b1) begin miscompares++; $display("FAIL bp_rx_ready_after_lo: got %b, required 1", bus.rx_ready); end
        if (bus.tx_valid !== 1'b0) begin miscompares++; $display("FAIL bp_tx_valid_after_lo: got %b, required 0", bus.tx_valid); end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        $display("rx word 01 accepted at cycle %0d", cyc);
        bus.tx_ready = 1'b1;
        send_word(8'd10, t_acc);
        send_word(8'd20, t_acc);
        recv_resp(s, h, l, t_first);
        vectors += 3;
        if (s !== 8'h00) begin miscompares++; $display("FAIL bp_next_status: got %h, required 00", s); end
        if (h !== 8'h1E) begin miscompares++; $display("FAIL bp_next_hi: got %h, required 1E", h); end
        if (l !== 8'h00) begin miscompares++; $display("FAIL bp_next_lo: got %h, required 00", l); end
    endtask

    task automatic test_reset_mid_wait;
        int t_acc, t_first, pulses;
        logic [7:0] s, h, l;
        alu_delay = 4;
        pulses = alu_pulses;
        send_cmd(8'h02, 8'h03, 8'h04, t_acc);
        @(negedge clk);
        reset = 1'b0;
        #1;
        vectors += 6;
        if (bus.rx_ready !== 1'b1) begin miscompares++; $display("FAIL rst_wait_rx_ready: got %b, required 1", bus.rx_ready); end
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_wait_busy: got %b, required 0", bus.busy); end
        if (bus.tx_valid !== 1'b0) begin miscompares++; $display("FAIL rst_wait_tx_valid: got %b, required 0", bus.tx_valid); end
        if (bus.alu_op_code !== 8'h00) begin miscompares++; $display("FAIL rst_wait_op_code: got %h, required 00", bus.alu_op_code); end
        if (bus.alu_num_1 !== 8'h00) begin miscompares++; $display("FAIL rst_wait_num_1: got %h, required 00", bus.alu_num_1); end
        if (bus.alu_num_2 !== 8'h00) begin miscompares++; $display("FAIL rst_wait_num_2: got %h, required 00", bus.alu_num_2); end
        @(negedge clk);
        reset = 1'b1;
        repeat (6) begin
            @(negedge clk);
            vectors += 2;
            if (bus.tx_valid !== 1'b0) begin miscompares++; $display("FAIL rst_stale_tx_valid: got %b, required 0", bus.tx_valid); end
            if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_stale_busy: got %b, required 0", bus.busy); end
        end
        vectors += 1;
        if (alu_pulses - pulses !== 1) begin miscompares++; $display("FAIL rst_stale_pulse_seen: got %0d pulses, required 1", alu_pulses - pulses); end
        alu_delay = 0;
        send_cmd(8'h02, 8'h03, 8'h04, t_acc);
        recv_resp(s, h, l, t_first);
        vectors += 3;
        if (s !== 8'h00) begin miscompares++; $display("FAIL mul_status: got %h, required 00", s); end
        if (h !== 8'h0C) begin miscompares++; $display("FAIL mul_hi: got %h, required 0C", h); end
        if (l !== 8'h00) begin miscompares++; $display("FAIL mul_lo: got %h, required 00", l); end
    endtask

    initial begin
        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        test_reset;
        test_add;
        test_div;
        test_div_zero;
        test_timeout;
        test_timeout_race;
        test_backpressure;
        test_reset_mid_wait;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Command sequencer between the co-processor host word stream and the shared ALU.
- Collects a 3-word command (op code, operand 1, operand 2) over a valid/ready input stream and issues a one-cycle ALU request.
- Waits for the ALU's completion pulse and returns a 3-word response (status, result_Hi, result_Lo) over a valid/ready output stream.
- Screens divide-by-zero and times out unsupported op codes, which the ALU never acknowledges.

Parameters:
- bitness, 8, operand/result/stream word width (>= 8)
- div, 8'b00000100, op code checked for divide-by-zero
- timeout, 16, max cycles waiting for alu_o_ready after issue (>= 2)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- rx_data  in  bitness  command word; op code is rx_data[7:0] in word 0
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  sequencer accepts rx_data
- alu_num_1  out  bitness  operand 1 to ALU
- alu_num_2  out  bitness  operand 2 to ALU
- alu_op_code  out  8  op code to ALU
- alu_i_ready  out  1  one-cycle ALU request strobe
- alu_result_Hi  in  bitness  ALU result high / quotient
- alu_result_Lo  in  bitness  ALU result low / remainder
- alu_o_ready  in  1  ALU completion pulse (registered, one cycle)
- tx_data  out  bitness  response word
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  consumer accepts tx_data
- busy  out  1  high in every state except GET_OP

Behaviour:
- Reset (reset=0, async): state GET_OP; all outputs 0 except rx_ready=1; latched operands, results, status and timer cleared; any in-flight command is discarded. Late alu_o_ready pulses after reset release are ignored in GET_OP/GET_A/GET_B.
- Transfer rule: a word moves on a rising edge with valid && ready. tx_data and tx_valid are registered and stay stable while tx_valid && !tx_ready.
- States:
  - GET_OP: rx_ready=1. On transfer, latch op, go to GET_A.
  - GET_A: rx_ready=1. On transfer, latch operand 1, go to GET_B.
  - GET_B: rx_ready=1. On transfer, latch operand 2. If op==div and rx_data==0: status=8'h01, Hi=Lo=0, go to SEND_ST without issuing. Otherwise go to ISSUE.
  - ISSUE: rx_ready=0; alu_i_ready=1 for exactly this one cycle; timer cleared; go to WAIT.
  - WAIT: alu_i_ready=0; alu_num_1, alu_num_2 and alu_op_code held stable.
    - alu_o_ready=1: latch Hi/Lo, status=8'h00, go to SEND_ST.
    - Else if timer == timeout-1: status=8'h02, Hi=Lo=0, go to SEND_ST.
    - Otherwise increment timer.
  - SEND_ST, SEND_HI, SEND_LO: tx_valid=1, tx_data = status (zero-extended to bitness), Hi, Lo respectively. Advance on tx_ready; from SEND_LO go to GET_OP.
- ALU outputs: alu_num_1, alu_num_2 and alu_op_code change only at GET_B acceptance; they retain their last values in all other states.
- Latency, OK path: operand 2 accepted at edge E; alu_i_ready high during cycle E..E+1; ALU pulse seen in cycle E+1..E+2; tx_valid (status) asserted from edge E+2.
- Timeout path: status emitted timeout+1 cycles after issue.
- Timing edge cases:
  - alu_o_ready arriving on the same edge the timer expires counts as success.
  - rx_valid held high while busy in ISSUE, WAIT or SEND_*: no word is consumed.
  - Back-to-back commands: the next command's op is accepted only after SEND_LO completes.
- Arithmetic: no width conversion; ALU results are forwarded unmodified.

Test Plan:
- Add, bitness=8: rx 01,05,03 with tx_ready=1 -> exactly one alu_i_ready pulse; tx 00,08,00; tx_valid rises 2 cycles after operand 2 accepted.
- Divide: rx 04,17,05 -> tx 00,03,02.
- Divide by zero: rx 04,09,00 -> alu_i_ready never asserted; tx 01,00,00.
- Unsupported op: rx 07,01,01 with ALU model silent -> tx 02,00,00 exactly timeout+1 cycles after issue.
- Output backpressure: add 02,03 with tx_ready low for 5 cycles at each word -> tx_data stable while stalled, busy=1, rx_ready=0; the following command is accepted only after the Lo word.
- Reset mid-WAIT: reset low for 1 cycle during WAIT with a delayed ALU pulse -> outputs 0 immediately, rx_ready=1, stale alu_o_ready ignored; next command mul 03,04 -> tx 00,0C,00.
